// File: rtl/cache_ways_nway_if.sv
// rtl/cache_ways_nway_if.sv - lookup, write, fill, victim and flush/writeback signals of the N-way cache
interface cache_ways_nway_if #(
   parameter int WAYS       = 4,
   parameter int SETS       = 8,
   parameter int LINE_BYTES = 16,
   parameter int ADDR_W     = 16
);
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W  = $clog2(WAYS);

   logic [ADDR_W-1:0] addr;
   logic              access;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [15:0]       rd_data;
   logic              wr_en;
   logic [15:0]       wr_data;
   logic [1:0]        wr_mask;
   logic              fill_en;
   logic [LINE_W-1:0] fill_data;
   logic [WAY_W-1:0]  victim_way;
   logic              victim_valid;
   logic              victim_dirty;
   logic [TAG_W-1:0]  victim_tag;
   logic [LINE_W-1:0] victim_data;
   logic              flush_start;
   logic              flush_busy;
   logic              flush_done;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [LINE_W-1:0] wb_data;

   // Cache control / memory side
   modport master (
      output addr, access, wr_en, wr_data, wr_mask, fill_en, fill_data, flush_start, wb_ready,
      input  hit, hit_way, rd_data, victim_way, victim_valid, victim_dirty, victim_tag,
             victim_data, flush_busy, flush_done, wb_valid, wb_addr, wb_data
   );

   // Cache storage side
   modport slave (
      input  addr, access, wr_en, wr_data, wr_mask, fill_en, fill_data, flush_start, wb_ready,
      output hit, hit_way, rd_data, victim_way, victim_valid, victim_dirty, victim_tag,
             victim_data, flush_busy, flush_done, wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/cache_ways_nway.sv
// rtl/cache_ways_nway.sv - N-way set-associative storage with tree PLRU, byte-merge writes and flush engine
module cache_ways_nway #(
   parameter int WAYS       = 4,
   parameter int SETS       = 8,
   parameter int LINE_BYTES = 16,
   parameter int ADDR_W     = 16
) (
   input logic              clk,
   input logic              reset,
   cache_ways_nway_if.slave bus
);
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int NODES  = WAYS - 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

   // Storage arrays; tag and data are deliberately left unreset
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [NODES-1:0]  plru_q  [SETS];

   // Flush engine state and registered outputs
   state_t            state_q;
   logic [IDX_W-1:0]  scan_set_q;
   logic [WAY_W-1:0]  scan_way_q;
   logic              busy_q;
   logic              done_q;
   logic              wb_valid_q;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [LINE_W-1:0] wb_data_q;

   // Address fields
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [OFF_W-2:0]  word_sel;
   logic              addr_lsb_unused;

   assign idx             = bus.addr[OFF_W+IDX_W-1:OFF_W];
   assign tag             = bus.addr[ADDR_W-1:OFF_W+IDX_W];
   assign word_sel        = bus.addr[OFF_W-1:1];
   assign addr_lsb_unused = bus.addr[0];

   // Lookup and victim results
   logic              hit_c;
   logic [WAY_W-1:0]  hit_way_c;
   logic [LINE_W-1:0] hit_line;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  plru_way;
   logic [WAY_W-1:0]  victim_way_c;
   logic [LINE_W-1:0] merged_line;

   // Per-cycle write/touch decisions, all suppressed while flushing
   logic              do_fill;
   logic              do_wr;
   logic              do_touch;
   logic [WAY_W-1:0]  touch_way;
   logic              last_slot;

   // Point every node on way w's path away from w
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] cur,
                                                   input logic [WAY_W-1:0] w);
      logic [NODES-1:0] r;
      int               node;
      r    = cur;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         r[node] = ~w[WAY_W-1-l];
         node    = 2 * node + 1 + int'(w[WAY_W-1-l]);
      end
      return r;
   endfunction

   // Tag compare across the set; lowest matching valid way wins
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit_c && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
      end
   end

   assign hit_line = data_q[idx][hit_way_c];

   // Victim: lowest invalid way, else walk the PLRU tree from the root
   always_comb begin
      int node;
      inv_found = 1'b0;
      inv_way   = '0;
      plru_way  = '0;
      node      = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (!inv_found && !valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      for (int l = 0; l < WAY_W; l++) begin
         plru_way[WAY_W-1-l] = plru_q[idx][node];
         node                = 2 * node + 1 + int'(plru_q[idx][node]);
      end
      victim_way_c = inv_found ? inv_way : plru_way;
   end

   // Byte-enable merge of the write word into the hit line
   always_comb begin
      merged_line = hit_line;
      for (int b = 0; b < 2; b++) begin
         if (bus.wr_mask[b]) begin
            merged_line[int'(word_sel)*16 + 8*b +: 8] = bus.wr_data[8*b +: 8];
         end
      end
   end

   assign do_fill   = !busy_q && bus.fill_en;
   assign do_wr     = !busy_q && bus.wr_en && hit_c && !bus.fill_en;
   assign do_touch  = do_fill || (!busy_q && hit_c && (bus.access || bus.wr_en));
   assign touch_way = do_fill ? victim_way_c : hit_way_c;
   assign last_slot = (scan_set_q == IDX_W'(SETS-1)) && (scan_way_q == WAY_W'(WAYS-1));

   // Tag/data array writes: fill into victim, or merged write into hit way
   always_ff @(posedge clk) begin
      if (do_fill) begin
         tag_q[idx][victim_way_c]  <= tag;
         data_q[idx][victim_way_c] <= bus.fill_data;
      end else if (do_wr) begin
         data_q[idx][hit_way_c] <= merged_line;
      end
   end

   // Valid/dirty/PLRU state, including flush-driven dirty clear and final invalidate
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (do_fill) begin
            valid_q[idx][victim_way_c] <= 1'b1;
            dirty_q[idx][victim_way_c] <= 1'b0;
         end else if (do_wr) begin
            dirty_q[idx][hit_way_c] <= 1'b1;
         end
         if (do_touch) begin
            plru_q[idx] <= plru_touch(plru_q[idx], touch_way);
         end
         if (state_q == S_WB && bus.wb_ready) begin
            dirty_q[scan_set_q][scan_way_q] <= 1'b0;
         end
         if (state_q == S_DONE) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[s] <= '0;
            end
         end
      end
   end

   // Flush FSM: scan every slot way-major, write back dirty lines, then invalidate
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         scan_set_q <= '0;
         scan_way_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wb_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.flush_start) begin
                  state_q    <= S_SCAN;
                  scan_set_q <= '0;
                  scan_way_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_SCAN: begin
               if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
                  state_q    <= S_WB;
                  wb_valid_q <= 1'b1;
                  wb_addr_q  <= {tag_q[scan_set_q][scan_way_q], scan_set_q, {OFF_W{1'b0}}};
                  wb_data_q  <= data_q[scan_set_q][scan_way_q];
               end else if (last_slot) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (scan_way_q == WAY_W'(WAYS-1)) begin
                  scan_way_q <= '0;
                  scan_set_q <= scan_set_q + 1'b1;
               end else begin
                  scan_way_q <= scan_way_q + 1'b1;
               end
            end
            S_WB: begin
               if (bus.wb_ready) begin
                  wb_valid_q <= 1'b0;
                  if (last_slot) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SCAN;
                     if (scan_way_q == WAY_W'(WAYS-1)) begin
                        scan_way_q <= '0;
                        scan_set_q <= scan_set_q + 1'b1;
                     end else begin
                        scan_way_q <= scan_way_q + 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hit          = hit_c;
   assign bus.hit_way      = hit_c ? hit_way_c : '0;
   assign bus.rd_data      = hit_c ? hit_line[int'(word_sel)*16 +: 16] : 16'h0000;
   assign bus.victim_way   = victim_way_c;
   assign bus.victim_valid = valid_q[idx][victim_way_c];
   assign bus.victim_dirty = dirty_q[idx][victim_way_c];
   assign bus.victim_tag   = tag_q[idx][victim_way_c];
   assign bus.victim_data  = data_q[idx][victim_way_c];
   assign bus.flush_busy   = busy_q;
   assign bus.flush_done   = done_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_addr      = wb_addr_q;
   assign bus.wb_data      = wb_data_q;
endmodule

// File: doc/cache_ways_nway.md
Name: cache_ways_nway

Overview:
- Parametrised N-way set-associative cache storage and lookup block for the lc3b memory hierarchy; successor to the fixed 2-way set pair.
- Holds tag/valid/dirty/data arrays with a per-set tree pseudo-LRU and victim selection.
- Does byte-masked write-hit merge and line fill.
- Has a self-sequenced flush engine that writes back every dirty line through a valid/ready port. It sits between the cache control FSM and the physical-memory interface.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, number of sets; power of two.
- LINE_BYTES, 16, bytes per line; LINE_W = 8*LINE_BYTES.
- ADDR_W, 16, address width. OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  lookup address; index = addr[OFF_W+IDX_W-1:OFF_W], tag = upper bits.
- access  in  1  qualified lookup this cycle; updates PLRU on hit.
- hit  out  1  some valid way's tag matches.
- hit_way  out  log2(WAYS)  matching way; 0 on miss.
- rd_data  out  16  aligned word at addr[OFF_W-1:1]; addr[0] ignored; 0 on miss.
- wr_en  in  1  write hit.
- wr_data  in  16  write word.
- wr_mask  in  2  byte enables; [0] = low byte.
- fill_en  in  1  write fill_data into victim_way at addr's set.
- fill_data  in  LINE_W  line; byte i at bits [8i+7:8i].
- victim_way  out  log2(WAYS)  replacement way for addr's set.
- victim_valid / victim_dirty  out  1 each  victim line state.
- victim_tag  out  TAG_W  victim tag.
- victim_data  out  LINE_W  victim line, for miss writeback.
- flush_start  in  1  begin flush.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle completion pulse.
- wb_valid  out  1  flush writeback request.
- wb_ready  in  1  writeback accepted.
- wb_addr  out  ADDR_W  {tag, set, OFF_W'b0}.
- wb_data  out  LINE_W  line being written back.

Behaviour:
- Reset: all valid, dirty and PLRU bits cleared; FSM goes to IDLE; flush_busy, flush_done and wb_valid are 0. Tag and data arrays are not reset.
- Lookup: hit, hit_way, rd_data and the victim_* outputs are combinational from addr and the current arrays. Writes become visible the cycle after the edge.
- Victim selection: lowest-index invalid way if any; otherwise follow the tree PLRU from the root.
  - PLRU has WAYS-1 bits per set; a node bit of 0 means descend left (lower ways).
  - On access-hit or fill of way w, every node on w's path is set to point away from w.
- wr_en with hit and not fill_en: merge enabled bytes of wr_data into the hit word, set dirty, update PLRU. wr_en on a miss is ignored. wr_mask = 0 changes no data but still sets dirty.
- fill_en: write data and tag to victim_way, valid = 1, dirty = 0, update PLRU. fill_en has priority over wr_en in the same cycle (wr_en dropped).
- While flush_busy = 1, access, wr_en and fill_en are ignored. flush_start while busy is ignored.
- Flush FSM: IDLE -> SCAN -> (WB) -> DONE -> IDLE.
  - flush_start in IDLE: enter SCAN at slot (set 0, way 0).
  - SCAN: one cycle per slot, way-major within set. A valid dirty slot goes to WB; otherwise advance. Advancing past slot (SETS-1, WAYS-1) goes to DONE.
  - WB: wb_valid = 1. wb_addr and wb_data stay stable until wb_valid && wb_ready. On that handshake, clear the slot's dirty bit and advance, returning to SCAN (or DONE after the last slot).
  - DONE: one cycle, flush_done = 1, all valid bits cleared at the end edge, then IDLE.
  - flush_busy = 1 in SCAN, WB and DONE.
  - A clean-cache flush keeps busy high for exactly SETS*WAYS+1 cycles.
- Reset mid-flush: FSM returns to IDLE and wb_valid deasserts the next cycle. No flush_done pulse. Arrays are handled per the reset rules above.

Test Plan:
1. Reset; addr=0x1234 -> hit=0, victim_way=0, victim_valid=0. Fill set 3 with word k = 0x1000+k; addr=0x1236 -> hit=1, hit_way=0, rd_data=0x1003.
2. Fill tags 0x10..0x13 into set 3 (ways 0,1,2,3 in order) -> victim_way=0. Access-hit way 0 -> victim_way=2.
3. Hit at 0x1236, wr_en, wr_mask=2'b10, wr_data=0xABCD -> next cycle rd_data=0xAB03, dirty set. Same with fill_en=1 at the same time -> write dropped, line equals fill_data.
4. One dirty line (tag of 0x1230, set 3), flush_start, wb_ready held low 3 cycles -> wb_valid stays high with wb_addr=0x1230 and stable wb_data. On ready: dirty cleared; flush_done pulses once; afterwards 0x1236 -> hit=0.
5. Clean-cache flush, default parameters -> flush_busy high exactly 33 cycles, wb_valid never high, a single flush_done pulse. A second flush_start mid-flush has no effect.
6. reset asserted while wb_valid=1 -> next cycle wb_valid=0, flush_busy=0, all lookups miss, flush_done never pulses.
